// File: rtl/input_capture_pio_if.sv
// Processor-side register bus for the input-capture PIO.
// The processor drives the master side; the peripheral is the slave.
interface input_capture_pio_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/input_capture_pio.sv
// Input-capture PIO for the stopwatch user inputs.
// Synchronizes and debounces the play button and three switches, then exposes
// the debounced levels, sticky edge flags, a press counter and a maskable
// level interrupt through a small 4-word register file.
module input_capture_pio #(
  parameter int DEBOUNCE_CYCLES = 500000,  // stable cycles before a level change is accepted (>= 2)
  parameter int CNT_W           = 20       // 2**CNT_W must exceed DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,        // asynchronous, active-low
  input  logic                play_btn_i,   // active-low pushbutton
  input  logic                switch_mode0_i,
  input  logic                switch_mode1_i,
  input  logic                switch_pause_i,
  input_capture_pio_if.slave  bus
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE     = 2'd2;
  localparam logic [1:0] ADDR_PRESSCNT = 2'd3;

  // Bit 0 is inverted up front so every bit reads 1 when "active".
  logic [3:0] raw_in;
  assign raw_in = {switch_pause_i, switch_mode1_i, switch_mode0_i, ~play_btn_i};

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] deb_q, deb_d;
  logic [3:0] flip_vec;
  logic [3:0] mask_q, mask_d;
  logic [3:0] edge_q, edge_d;
  logic [7:0] press_cnt_q, press_cnt_d;
  logic [31:0] readdata_q, readdata_d;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'h0;
      sync2_q <= 4'h0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce counter: counts consecutive cycles where the synchronized
  // input disagrees with the debounced level; a full run flips the level.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             flip;

      // Next counter value and flip request for this bit.
      always_comb begin
        cnt_d = '0;
        flip  = 1'b0;
        if (sync2_q[gi] != deb_q[gi]) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            flip  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Debounce counter state.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign flip_vec[gi] = flip;
    end
  endgenerate

  // Edge events are derived from the flip requests so EDGE/PRESSCNT update on
  // the same clock edge as DATA. Bit 0 only reports presses (0->1).
  logic       press;
  logic [3:0] edge_set;
  assign press    = flip_vec[0] & ~deb_q[0];
  assign edge_set = {flip_vec[3:1], press};

  logic wr_mask, wr_edge, wr_cnt;
  assign wr_mask = bus.write && (bus.address == ADDR_IRQMASK);
  assign wr_edge = bus.write && (bus.address == ADDR_EDGE);
  assign wr_cnt  = bus.write && (bus.address == ADDR_PRESSCNT);

  // Register-file next state; a new edge beats a simultaneous W1C, and a press
  // during a counter clear leaves the count at 1.
  always_comb begin
    deb_d  = deb_q ^ flip_vec;
    mask_d = wr_mask ? bus.writedata[3:0] : mask_q;
    edge_d = (edge_q & ~(wr_edge ? bus.writedata[3:0] : 4'h0)) | edge_set;
    if (wr_cnt) begin
      press_cnt_d = press ? 8'd1 : 8'd0;
    end else if (press) begin
      press_cnt_d = press_cnt_q + 8'd1;
    end else begin
      press_cnt_d = press_cnt_q;
    end
  end

  // Read mux uses current register values, so a read paired with a write
  // returns the pre-write contents.
  always_comb begin
    readdata_d = readdata_q;
    if (bus.read) begin
      case (bus.address)
        ADDR_DATA:     readdata_d = {28'd0, deb_q};
        ADDR_IRQMASK:  readdata_d = {28'd0, mask_q};
        ADDR_EDGE:     readdata_d = {28'd0, edge_q};
        ADDR_PRESSCNT: readdata_d = {24'd0, press_cnt_q};
        default:       readdata_d = 32'd0;
      endcase
    end
  end

  // Architectural registers and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q       <= 4'h0;
      mask_q      <= 4'h0;
      edge_q      <= 4'h0;
      press_cnt_q <= 8'd0;
      readdata_q  <= 32'd0;
    end else begin
      deb_q       <= deb_d;
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      press_cnt_q <= press_cnt_d;
      readdata_q  <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  // Interrupt is a pure AND/OR of registered state, so it cannot glitch.
  assign bus.irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_input_capture_pio.sv
// Scoreboard bench for input_capture_pio with a short debounce window.
module tb_input_capture_pio;
  localparam int DEB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic play_btn, sw0, sw1, swp;

  input_capture_pio_if bus ();

  input_capture_pio #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .play_btn_i     (play_btn),
    .switch_mode0_i (sw0),
    .switch_mode1_i (sw1),
    .switch_pause_i (swp),
    .bus            (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rvalid = 1'b0;

  // Read data is valid the cycle after the strobe.
  always @(posedge clk) rvalid <= bus.read;

  // Monitor: pop and compare each returned read.
  always @(negedge clk) begin
    if (rvalid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read got %h required none", bus.readdata);
      end else begin
        logic [31:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus.readdata !== e) begin
          n_fail++;
          $display("FAIL %s got %h required %h", nm, bus.readdata, e);
        end else begin
          $display("[TB] read %s = %h", nm, bus.readdata);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] e);
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s got %h required %h", nm, got, e);
    end else begin
      $display("[TB] check %s = %h", nm, got);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    bus.address = a;
    bus.read    = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    bus.read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e, input string nm);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    bus.read      = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic press_cycle();
    play_btn = 1'b0;
    tick(12);
    play_btn = 1'b1;
    tick(12);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    play_btn      = 1'b1;
    sw0           = 1'b0;
    sw1           = 1'b0;
    swp           = 1'b0;
    bus.address   = 2'd0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = 32'd0;

    // Reset state
    tick(3);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    reset = 1'b1;
    rd(2'd0, 32'd0, "rst_data");
    rd(2'd1, 32'd0, "rst_mask");
    rd(2'd2, 32'd0, "rst_edge");
    rd(2'd3, 32'd0, "rst_cnt");

    // Clean press: DATA[0] rises exactly DEB+2 cycles after the raw edge
    play_btn = 1'b0;
    for (int j = 0; j < 12; j++) rd(2'd0, (j >= DEB + 2) ? 32'd1 : 32'd0, "press_latency");
    tick(8);
    rd(2'd2, 32'd1, "press_edge");
    rd(2'd3, 32'd1, "press_cnt");
    wr(2'd1, 32'd1);
    chk("irq_masked_on", {31'd0, bus.irq}, 32'd1);
    wr(2'd2, 32'd1);
    chk("irq_after_w1c", {31'd0, bus.irq}, 32'd0);
    rd(2'd2, 32'd0, "edge_cleared");
    play_btn = 1'b1;
    tick(12);
    rd(2'd0, 32'd0, "release_data");
    rd(2'd2, 32'd0, "release_no_edge");
    rd(2'd3, 32'd1, "release_cnt");

    // Bouncing button: 5-cycle pulses never reach the debounce window
    wr(2'd3, 32'd0);
    rd(2'd3, 32'd0, "cnt_cleared");
    for (int k = 0; k < 60; k++) begin
      if (k % 5 == 0) play_btn = ((k / 5) % 2 == 0) ? 1'b0 : 1'b1;
      rd(2'd0, 32'd0, "bounce_data");
    end
    play_btn = 1'b0;
    tick(20);
    rd(2'd0, 32'd1, "bounce_settled");
    rd(2'd3, 32'd1, "bounce_cnt");
    rd(2'd2, 32'd1, "bounce_edge");
    wr(2'd2, 32'd1);
    wr(2'd1, 32'd0);
    play_btn = 1'b1;
    tick(12);

    // Switch toggle: both directions flag EDGE[2]; irq gated by mask
    sw1 = 1'b1;
    tick(20);
    chk("sw_on_irq", {31'd0, bus.irq}, 32'd0);
    rd(2'd0, 32'd4, "sw_on_data");
    sw1 = 1'b0;
    tick(20);
    chk("sw_off_irq", {31'd0, bus.irq}, 32'd0);
    rd(2'd0, 32'd0, "sw_off_data");
    rd(2'd2, 32'd4, "sw_edge");
    wr(2'd1, 32'd4);
    chk("sw_irq_masked", {31'd0, bus.irq}, 32'd1);
    rw(2'd1, 32'hFFFF_FFFF, 32'd4, "rw_pre_write");
    rd(2'd1, 32'hF, "mask_upper_ignored");
    wr(2'd2, 32'd4);
    chk("sw_irq_cleared", {31'd0, bus.irq}, 32'd0);
    wr(2'd1, 32'd0);

    // Press counter wrap, then a press coincident with a counter clear
    wr(2'd3, 32'd0);
    for (int p = 0; p < 256; p++) press_cycle();
    rd(2'd3, 32'd0, "cnt_wrap");
    play_btn = 1'b0;
    tick(DEB + 1);
    wr(2'd3, 32'd0);
    rd(2'd3, 32'd1, "cnt_write_vs_press");
    tick(5);
    play_btn = 1'b1;
    tick(12);

    // W1C of EDGE[0] on the same edge as a new press: set wins
    play_btn = 1'b0;
    tick(DEB + 1);
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd1, "w1c_vs_set");
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd0, "w1c_clear");
    play_btn = 1'b1;
    tick(12);

    // Reset mid-debounce discards the count and all registers
    wr(2'd1, 32'hF);
    rd(2'd1, 32'hF, "mask_pre_reset");
    swp = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(2);
    chk("midreset_readdata", bus.readdata, 32'd0);
    chk("midreset_irq", {31'd0, bus.irq}, 32'd0);
    reset = 1'b1;
    for (int j = 0; j < 12; j++) rd(2'd0, (j >= DEB + 2) ? 32'd8 : 32'd0, "restart_latency");
    rd(2'd1, 32'd0, "mask_after_reset");
    rd(2'd2, 32'd8, "edge_pause");
    rd(2'd3, 32'd0, "cnt_after_reset");
    chk("irq_after_reset", {31'd0, bus.irq}, 32'd0);

    tick(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/input_capture_pio.md
# input_capture_pio

Avalon-MM slave peripheral that conditions the stopwatch's raw user inputs (play button, mode switches, pause switch) and presents them to the processor as debounced level bits, sticky edge flags and a press counter, with a maskable interrupt. It is the responder side of the processor's input-PIO interface. It sits between the board pins and the processor bus, replacing plain input PIOs for those four signals.

## Interface
- DEBOUNCE_CYCLES, 500000, stable-input cycles required before a debounced bit changes (10 ms at 50 MHz); must be ≥ 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- play_btn  in  1  raw pushbutton, active-low (pressed = 0), asynchronous to clk.
- switch_mode0  in  1  raw slide switch, active-high, asynchronous.
- switch_mode1  in  1  raw slide switch, active-high, asynchronous.
- switch_pause  in  1  raw slide switch, active-high, asynchronous.
- address  in  2  word address of the register.
- read  in  1  read strobe, one-cycle pulse per access.
- write  in  1  write strobe, one-cycle pulse per access.
- writedata  in  32  write data.
- readdata  out  32  read data, registered, valid the cycle after read.
- irq  out  1  level interrupt, active-high.

## Operation
- Input vector in[3:0] = {switch_pause, switch_mode1, switch_mode0, ~play_btn}; bit 0 is 1 while pressed.
- Each bit goes through a 2-flop synchronizer (reset value 0 post-inversion, i.e. play_btn flops reset to 1).
- Per-bit debounce: when sync bit ≠ debounced bit, counter increments; when equal, counter clears. When counter reaches DEBOUNCE_CYCLES−1 while still differing, debounced bit takes the sync value and counter clears. Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edge detect on debounced bits: bit 0 sets EDGE[0] on 0→1 only (press); bits 3:1 set EDGE[n] on any change.
- Press counter: 8-bit, increments on each debounced 0→1 of bit 0, wraps 255→0.
- Register map (word addresses):
  - 0 DATA, RO: [3:0] debounced bits, [31:4] 0.
  - 1 IRQMASK, RW: [3:0] mask, [31:4] read 0, writes ignored.
  - 2 EDGE, R/W1C: [3:0] sticky flags; writing 1 clears that bit, 0 leaves it.
  - 3 PRESSCNT, RO: [7:0] count; any write clears it to 0.
- irq = |(EDGE & IRQMASK), driven from registers (glitch-free).
- Simultaneous W1C and new edge on the same EDGE bit: set wins (flag stays 1). Simultaneous PRESSCNT write and press: count becomes 1.
- read and write asserted together: write performed, readdata returns pre-write value.

## Timing
- Reset values: readdata 0, irq 0, DATA 0, IRQMASK 0, EDGE 0, PRESSCNT 0, all debounce counters 0.
- Switches already on at reset release debounce normally and produce an EDGE flag DEBOUNCE_CYCLES+2 cycles after release; software clears it at init.
- Input-to-DATA latency: 2 (sync) + DEBOUNCE_CYCLES cycles from a clean raw transition.
- DATA change to EDGE/PRESSCNT update: same edge as DATA update; irq asserts 0 cycles after EDGE (combinational from regs).
- Read latency fixed 1 cycle, no waitrequest; back-to-back reads every cycle supported.
- Write takes effect at the clk edge where write=1; readback on following cycle's read shows new value.
- Reset mid-debounce discards the count; reset mid-access drops the access.

## Test plan
- Reset with all inputs inactive -> every register reads 0, irq 0; readdata 0 during reset.
- DEBOUNCE_CYCLES=8; play_btn low for 20 cycles -> DATA[0]=1 exactly 10 cycles after the raw edge, EDGE=0x1, PRESSCNT=1; IRQMASK=0x1 -> irq=1; write EDGE=0x1 -> irq=0 next cycle.
- play_btn bouncing with 5-cycle pulses for 60 cycles then stable low -> exactly one press, PRESSCNT=1, no intermediate DATA toggles.
- Toggle switch_mode1 on then off (each held 20 cycles), mask 0 -> EDGE[2]=1, irq stays 0; set IRQMASK=0x4 -> irq=1.
- 256 clean presses -> PRESSCNT wraps to 0; one more press coincident with a PRESSCNT write -> reads 1.
- Press edge on same cycle as W1C write of EDGE[0] -> EDGE[0] reads 1; assert reset mid-debounce -> all registers 0 and counting restarts after release.
